// File: rtl/param_sr_counter.sv
// param_sr_counter: start/stop event counter with configurable width, direction,
// prescaler, terminal value and terminal action (wrap / saturate / one-shot).
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   S_IDLE | after reset or clear; count frozen, waiting for start
//   S_RUN  | prescaler running, count advances on every tick
//   S_HALT | stopped by stop; count held, start resumes from it
//   S_DONE | one-shot terminal reached; count held, start re-runs
module param_sr_counter #(
   parameter int WIDTH      = 16,
   parameter int PRESCALE_W = 8,
   parameter int MODE       = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  clear,
   input  logic                  load,
   input  logic [WIDTH-1:0]      load_value,
   input  logic                  dir,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic [WIDTH-1:0]      limit,
   output logic [WIDTH-1:0]      count,
   output logic                  running,
   output logic                  tc_pulse,
   output logic                  done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t                state_q, state_nxt;
   logic [WIDTH-1:0]      count_q, count_nxt;
   logic [PRESCALE_W-1:0] pre_q, pre_nxt, pre_inc;
   logic                  armed_q, armed_nxt;
   logic                  tc_nxt;
   logic                  tick;
   logic                  terminal;

   // Prescaler compare uses >= so lowering prescale below the running
   // pre-count still ticks promptly instead of waiting for a full wrap.
   assign pre_inc  = pre_q + PRESCALE_W'(1);
   assign tick     = (state_q == S_RUN) && (pre_q >= prescale);
   assign terminal = dir ? (count_q >= limit) : (count_q == '0);

   // Next-state, count, prescaler and terminal-pulse decode in priority order
   // clear > load > stop > start > tick.
   always_comb begin
      state_nxt = state_q;
      count_nxt = count_q;
      pre_nxt   = pre_q;
      armed_nxt = armed_q;
      tc_nxt    = 1'b0;
      if (clear) begin
         state_nxt = S_IDLE;
         count_nxt = '0;
         pre_nxt   = '0;
         armed_nxt = 1'b1;
      end else if (load) begin
         // Loaded value replaces this edge's tick; prescaler keeps its cadence.
         count_nxt = load_value;
         armed_nxt = 1'b1;
         if (state_q == S_RUN) begin
            pre_nxt = tick ? '0 : pre_inc;
         end
      end else if (stop && ((state_q == S_RUN) || start)) begin
         // start+stop together anywhere lands in HALT: stop wins.
         state_nxt = S_HALT;
      end else if (start && (state_q != S_RUN)) begin
         state_nxt = S_RUN;
         pre_nxt   = '0;
         armed_nxt = 1'b1;
      end else if (state_q == S_RUN) begin
         pre_nxt = tick ? '0 : pre_inc;
         if (tick) begin
            if (terminal) begin
               if (MODE == 1) begin
                  tc_nxt    = armed_q;
                  armed_nxt = 1'b0;
               end else if (MODE == 2) begin
                  tc_nxt    = 1'b1;
                  state_nxt = S_DONE;
               end else begin
                  tc_nxt    = 1'b1;
                  count_nxt = dir ? '0 : limit;
               end
            end else begin
               count_nxt = dir ? (count_q + WIDTH'(1)) : (count_q - WIDTH'(1));
            end
         end
      end
   end

   // State, count, prescaler and registered status outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         count_q  <= '0;
         pre_q    <= '0;
         armed_q  <= 1'b1;
         tc_pulse <= 1'b0;
         running  <= 1'b0;
         done     <= 1'b0;
      end else begin
         state_q  <= state_nxt;
         count_q  <= count_nxt;
         pre_q    <= pre_nxt;
         armed_q  <= armed_nxt;
         tc_pulse <= tc_nxt;
         running  <= (state_nxt == S_RUN);
         done     <= (state_nxt == S_DONE);
      end
   end

   assign count = count_q;

endmodule
